// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_pkg
//  Description : Shared definitions for the TDC measurement sequencer.
//                Holds the FSM state encoding, the TDC register addresses
//                and the default CONFIG1 word.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package tdc_pkg;

  // TDC register map
  localparam logic [5:0] ADDR_CONFIG1     = 6'h00;
  localparam logic [5:0] ADDR_TIME1       = 6'h10;

  // CONFIG1 value with the start-measurement bit set
  localparam logic [7:0] CFG_WORD_DEFAULT = 8'h01;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_CFG_WR   = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_INT = 3'd3,
    ST_RD_TIME  = 3'd4,
    ST_OUTPUT   = 3'd5,
    ST_ERR      = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tdc_meas_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_meas_sequencer_if
//  Description : Bus bundle between the sequencer and its environment:
//                an SPI-style register access channel towards the TDC and
//                a valid/ready result channel towards the consumer.
//  Signals     : spi_req/spi_wr/spi_addr/spi_wdata  request (master drives)
//                spi_ack/spi_rdata                  completion (slave drives)
//                res_data/res_valid                 result (master drives)
//                res_ready                          result accept (slave drives)
//  Modports    : master = sequencer side, slave = environment side
//  Revision    : 1.0  initial release
// ============================================================================
interface tdc_meas_sequencer_if;

  logic        spi_req;
  logic        spi_wr;
  logic [5:0]  spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_ack;
  logic [23:0] spi_rdata;

  logic [23:0] res_data;
  logic        res_valid;
  logic        res_ready;

  modport master (
    output spi_req, spi_wr, spi_addr, spi_wdata,
    input  spi_ack, spi_rdata,
    output res_data, res_valid,
    input  res_ready
  );

  modport slave (
    input  spi_req, spi_wr, spi_addr, spi_wdata,
    output spi_ack, spi_rdata,
    input  res_data, res_valid,
    output res_ready
  );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous level.
//  Ports       : clk    in  clock
//                rst    in  synchronous active-high reset (flops -> RESET_VAL)
//                i_d    in  asynchronous input
//                o_q    out synchronized output
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/tdc_meas_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_meas_sequencer
//  Description : Drives one TDC measurement at a time: writes CONFIG1,
//                pulses the start line, waits for the (active-low) TDC
//                interrupt with a timeout, reads TIME1 and hands the result
//                out over a valid/ready channel.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                i_enable        TDC booted and usable
//                i_pause         inhibit new measurements
//                i_soft_reset    abort request
//                bus (master)    SPI request/ack + result valid/ready
//                o_trig_start    start pulse to TDC/emitter
//                i_intb          asynchronous active-low TDC interrupt
//                o_timeout_err   one-cycle pulse on interrupt timeout
//                o_busy          high whenever not idle
//                o_meas_cnt      count of accepted results (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module tdc_meas_sequencer
  import tdc_pkg::*;
#(
  parameter logic [3:0]  START_WIDTH = 4'd4,
  parameter logic [19:0] TIMEOUT     = 20'd200000,
  parameter logic [7:0]  CFG_WORD    = CFG_WORD_DEFAULT
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_enable,
  input  wire logic              i_pause,
  input  wire logic              i_soft_reset,
  tdc_meas_sequencer_if.master   bus,
  output logic                   o_trig_start,
  input  wire logic              i_intb,
  output logic                   o_timeout_err,
  output logic                   o_busy,
  output logic [15:0]            o_meas_cnt
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_start_cnt;
  logic [19:0] r_tmo_cnt;
  logic        r_abort;
  logic [23:0] r_res_data;
  logic [15:0] r_meas_cnt;
  logic        w_intb_s;
  logic        w_abort;
  logic        w_accept;

  sync_2ff #(.RESET_VAL(1'b1)) u_intb_sync (
    .clk (clk),
    .rst (rst),
    .i_d (i_intb),
    .o_q (w_intb_s)
  );

  // An abort seen during an SPI transfer counts whether it arrived earlier
  // (latched) or in the ack cycle itself.
  assign w_abort  = r_abort | i_soft_reset;
  assign w_accept = (r_state == ST_OUTPUT) && bus.res_ready && !i_soft_reset;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (i_enable && !i_pause && !i_soft_reset) w_state_nxt = ST_CFG_WR;
      ST_CFG_WR:
        if (bus.spi_ack) w_state_nxt = w_abort ? ST_IDLE : ST_START;
      ST_START:
        if (i_soft_reset)                             w_state_nxt = ST_IDLE;
        else if (r_start_cnt == START_WIDTH - 4'd1)   w_state_nxt = ST_WAIT_INT;
      ST_WAIT_INT:
        // Interrupt is checked before the timeout so a tie resolves as
        // a valid measurement.
        if (i_soft_reset)                         w_state_nxt = ST_IDLE;
        else if (!w_intb_s)                       w_state_nxt = ST_RD_TIME;
        else if (r_tmo_cnt == TIMEOUT - 20'd1)    w_state_nxt = ST_ERR;
      ST_RD_TIME:
        if (bus.spi_ack) w_state_nxt = w_abort ? ST_IDLE : ST_OUTPUT;
      ST_OUTPUT:
        if (i_soft_reset || bus.res_ready) w_state_nxt = ST_IDLE;
      ST_ERR:
        w_state_nxt = ST_IDLE;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state; spi_req therefore drops the
  // cycle after ack because every ack leaves the SPI states.
  always_comb begin
    bus.spi_req   = 1'b0;
    bus.spi_wr    = 1'b0;
    bus.spi_addr  = 6'h00;
    bus.spi_wdata = 8'h00;
    bus.res_valid = 1'b0;
    o_trig_start  = 1'b0;
    o_timeout_err = 1'b0;
    case (r_state)
      ST_CFG_WR: begin
        bus.spi_req   = 1'b1;
        bus.spi_wr    = 1'b1;
        bus.spi_addr  = ADDR_CONFIG1;
        bus.spi_wdata = CFG_WORD;
      end
      ST_START:    o_trig_start  = 1'b1;
      ST_RD_TIME: begin
        bus.spi_req   = 1'b1;
        bus.spi_addr  = ADDR_TIME1;
      end
      ST_OUTPUT:   bus.res_valid = 1'b1;
      ST_ERR:      o_timeout_err = 1'b1;
      default: ;
    endcase
  end

  // Datapath: counters, abort latch, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_cnt <= 4'd0;
      r_tmo_cnt   <= 20'd0;
      r_abort     <= 1'b0;
      r_res_data  <= 24'd0;
      r_meas_cnt  <= 16'd0;
    end else begin
      r_start_cnt <= (r_state == ST_START)    ? r_start_cnt + 4'd1 : 4'd0;
      r_tmo_cnt   <= (r_state == ST_WAIT_INT) ? r_tmo_cnt + 20'd1  : 20'd0;
      if ((r_state == ST_CFG_WR) || (r_state == ST_RD_TIME))
        r_abort <= w_abort;
      else
        r_abort <= 1'b0;
      if ((r_state == ST_RD_TIME) && bus.spi_ack && !w_abort)
        r_res_data <= bus.spi_rdata;
      // Free-running 16-bit add: wraps to zero silently.
      r_meas_cnt <= r_meas_cnt + {15'd0, w_accept};
    end
  end

  assign bus.res_data = r_res_data;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_meas_cnt   = r_meas_cnt;

endmodule
`default_nettype wire

// File: doc/tdc_meas_sequencer.md
TDC_MEAS_SEQUENCER -- requirements
Module: tdc_meas_sequencer

Interface
REQ-001 The block SHALL have parameter START_WIDTH, default 4, meaning the trig_start pulse length in clk cycles (range 1..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 20'd200000, meaning the maximum number of cycles to wait for the TDC interrupt.
REQ-003 The block SHALL have parameter CFG_WORD, default 8'h01, meaning the CONFIG1 value written per measurement (start-measurement bit set).
REQ-004 The block SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-005 The block SHALL have ports: enable in 1 TDC booted and usable; pause in 1 inhibit new measurements; soft_reset in 1 abort request.
REQ-006 The block SHALL have ports: spi_req out 1; spi_wr out 1 (1=write); spi_addr out 6; spi_wdata out 8; spi_ack in 1 one-cycle completion; spi_rdata in 24 read data, valid with spi_ack.
REQ-007 The block SHALL have ports: trig_start out 1 start pulse to TDC/emitter; intb in 1 active-low asynchronous TDC interrupt.
REQ-008 The block SHALL have ports: res_data out 24; res_valid out 1; res_ready in 1; timeout_err out 1 one-cycle pulse; busy out 1 state != IDLE; meas_cnt out 16 accepted-result count.

Function
REQ-009 The FSM SHALL use states IDLE, CFG_WR, START, WAIT_INT, RD_TIME, OUTPUT, ERR.
REQ-010 IDLE -> CFG_WR when enable=1 and pause=0 and soft_reset=0; otherwise it SHALL stay in IDLE.
REQ-011 CFG_WR SHALL drive spi_req=1, spi_wr=1, spi_addr=6'h00, spi_wdata=CFG_WORD, all stable until spi_ack=1; on ack -> START.
REQ-012 spi_req SHALL drop to 0 in the cycle after spi_ack is sampled; it SHALL never be re-asserted in that same cycle.
REQ-013 START SHALL hold trig_start=1 for exactly START_WIDTH cycles, then -> WAIT_INT with the timeout counter cleared.
REQ-014 intb SHALL pass through a 2-flop synchronizer; WAIT_INT -> RD_TIME on synchronized intb=0.
REQ-015 The WAIT_INT counter SHALL be 20 bits; on reaching TIMEOUT-1 without interrupt -> ERR; an interrupt and timeout in the same cycle SHALL resolve as interrupt.
REQ-016 RD_TIME SHALL issue a read (spi_wr=0, spi_addr=6'h10) under REQ-011/012 rules and capture spi_rdata into res_data on ack, then -> OUTPUT.
REQ-017 OUTPUT SHALL hold res_valid=1 and res_data stable until res_ready=1; on the accept cycle -> IDLE and meas_cnt increments.
REQ-018 meas_cnt SHALL wrap 16'hFFFF -> 16'h0000 without any flag.
REQ-019 ERR SHALL pulse timeout_err=1 for one cycle and -> IDLE; res_data is unchanged.
REQ-020 soft_reset in START or WAIT_INT SHALL -> IDLE next cycle with trig_start=0 and no error pulse.
REQ-021 soft_reset in CFG_WR or RD_TIME SHALL be latched; the transaction completes on spi_ack, then -> IDLE (read data discarded, res_valid stays 0).
REQ-022 soft_reset in OUTPUT SHALL drop res_valid and -> IDLE without incrementing meas_cnt.
REQ-023 pause and enable SHALL only be evaluated in IDLE; a measurement in progress completes.

Reset
REQ-024 On rst, state=IDLE and spi_req, spi_wr, trig_start, res_valid, timeout_err, busy SHALL be 0.
REQ-025 On rst, spi_addr, spi_wdata, res_data, meas_cnt, counters, synchronizer flops (to 1) and soft_reset latch SHALL be cleared.
REQ-026 rst SHALL take priority over every other input, including mid-SPI transaction; a late spi_ack after reset SHALL be ignored in IDLE.

Structure
REQ-027 A shared package tdc_pkg SHALL hold the state encoding, register addresses (ADDR_CONFIG1=6'h00, ADDR_TIME1=6'h10) and the CFG_WORD default.
REQ-028 The synchronizer SHALL be one sub-module, sync_2ff; all other logic resides in tdc_meas_sequencer.

Verification
REQ-029 Nominal: enable=1, spi_ack 3 cycles after each req, intb low 50 cycles after start, rdata=24'h00ABCD -> one write to 0x00 data 8'h01, 4-cycle trig_start, read 0x10, res_data=24'h00ABCD, meas_cnt=1.
REQ-030 Backpressure: res_ready held 0 for 20 cycles -> res_valid and res_data stable for 20 cycles, no new spi_req until accept.
REQ-031 Timeout: TIMEOUT=100, intb held high -> timeout_err pulses exactly once, 100 cycles after WAIT_INT entry, then IDLE.
REQ-032 Abort: soft_reset during RD_TIME with ack delayed 5 cycles -> spi_req held until ack, then IDLE, res_valid never asserted.
REQ-033 Wrap and pause: preload 65535 accepts -> next accept gives meas_cnt=0; pause=1 in IDLE -> no spi_req for 100 cycles.
